execute_cycle: RTL and testbench

- Execute stage of the 5-stage RV32I pipeline.
- Sits between the ID/EX register (decode stage outputs) and the memory stage.
- Applies forwarding to both operands, runs the ALU, resolves branches and jumps, and produces the redirect (PCSrcE/PCTargetE) for fetch.
- Registers all results into the EX/MEM pipeline register on the next rising clk edge.

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/alu.sv | 34 +++
 rtl/execute_cycle.sv | 126 ++++++++++++
 tb/tb_execute_cycle.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants: ALU operation codes, opcodes used by execute,
// forwarding selects and writeback selects.
package riscv_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU; undefined operation codes yield zero.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [3:0]      ALU_Control,
    output logic [XLEN-1:0] Result
);

    logic [4:0] shamt;

    assign shamt = B[4:0];

    always_comb begin
        Result = '0;
        case (ALU_Control)
            ALU_ADD:  Result = A + B;
            ALU_SUB:  Result = A - B;
            ALU_AND:  Result = A & B;
            ALU_OR:   Result = A | B;
            ALU_XOR:  Result = A ^ B;
            ALU_SLL:  Result = A << shamt;
            ALU_SRL:  Result = A >> shamt;
            ALU_SRA:  Result = $signed(A) >>> shamt;
            ALU_SLT:  Result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: Result = {{(XLEN-1){1'b0}}, (A < B)};
            default:  Result = '0;
        endcase
    end

endmodule

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution with a
// combinational fetch redirect, and the EX/MEM pipeline register.
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter bit RESET_PC_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic [1:0]      Mem_to_RegE,
    input  logic            MemReadE,
    input  logic            MemWriteE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            ALUSrcE,
    input  logic [2:0]      funct3E,
    input  logic [3:0]      ALU_ControlE,
    input  logic [6:0]      opE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [4:0]      RDE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemReadM,
    output logic            MemWriteM,
    output logic [1:0]      Mem_to_RegM,
    output logic [2:0]      funct3M,
    output logic [4:0]      RDM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    // Only the zero vector exists today; the parameter reserves the hook.
    localparam logic [XLEN-1:0] DATA_RST = RESET_PC_ZERO ? '0 : '0;

    logic [XLEN-1:0] src_a_fwd;
    logic [XLEN-1:0] src_b_fwd;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] jalr_sum;
    logic            taken;

    always_comb begin
        case (ForwardAE)
            FWD_WB:  src_a_fwd = ResultW;
            FWD_MEM: src_a_fwd = ALUResultM;
            default: src_a_fwd = RD1E;
        endcase
        case (ForwardBE)
            FWD_WB:  src_b_fwd = ResultW;
            FWD_MEM: src_b_fwd = ALUResultM;
            default: src_b_fwd = RD2E;
        endcase
    end

    always_comb begin
        if (opE == OP_AUIPC)
            alu_a = PCE;
        else if (opE == OP_LUI)
            alu_a = '0;
        else
            alu_a = src_a_fwd;
    end

    assign alu_b = ALUSrcE ? Imm_Ext_E : src_b_fwd;

    alu #(.XLEN(XLEN)) u_alu (
        .A           (alu_a),
        .B           (alu_b),
        .ALU_Control (ALU_ControlE),
        .Result      (alu_result)
    );

    // Branches compare register operands, never the immediate.
    always_comb begin
        case (funct3E)
            F3_BEQ:  taken = (src_a_fwd == src_b_fwd);
            F3_BNE:  taken = (src_a_fwd != src_b_fwd);
            F3_BLT:  taken = ($signed(src_a_fwd) <  $signed(src_b_fwd));
            F3_BGE:  taken = ($signed(src_a_fwd) >= $signed(src_b_fwd));
            F3_BLTU: taken = (src_a_fwd <  src_b_fwd);
            F3_BGEU: taken = (src_a_fwd >= src_b_fwd);
            default: taken = 1'b0;
        endcase
    end

    assign PCSrcE    = JumpE | (BranchE & taken);
    assign jalr_sum  = src_a_fwd + Imm_Ext_E;
    assign PCTargetE = (opE == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + Imm_Ext_E);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteM   <= 1'b0;
            MemReadM    <= 1'b0;
            MemWriteM   <= 1'b0;
            Mem_to_RegM <= '0;
            funct3M     <= '0;
            RDM         <= '0;
            ALUResultM  <= DATA_RST;
            WriteDataM  <= DATA_RST;
            PCPlus4M    <= DATA_RST;
        end else begin
            RegWriteM   <= RegWriteE;
            MemReadM    <= MemReadE;
            MemWriteM   <= MemWriteE;
            Mem_to_RegM <= Mem_to_RegE;
            funct3M     <= funct3E;
            RDM         <= RDE;
            ALUResultM  <= alu_result;
            WriteDataM  <= src_b_fwd;
            PCPlus4M    <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed self-checking bench for execute_cycle with hand-computed vectors.
module tb_execute_cycle;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        RegWriteE;
    logic [1:0]  Mem_to_RegE;
    logic        MemReadE;
    logic        MemWriteE;
    logic        BranchE;
    logic        JumpE;
    logic        ALUSrcE;
    logic [2:0]  funct3E;
    logic [3:0]  ALU_ControlE;
    logic [6:0]  opE;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, Imm_Ext_E;
    logic [4:0]  RDE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemReadM, MemWriteM;
    logic [1:0]  Mem_to_RegM;
    logic [2:0]  funct3M;
    logic [4:0]  RDM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int checks = 0;
    int errors = 0;

    execute_cycle #(.XLEN(32), .RESET_PC_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .Mem_to_RegE(Mem_to_RegE), .MemReadE(MemReadE),
        .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE), .ALUSrcE(ALUSrcE),
        .funct3E(funct3E), .ALU_ControlE(ALU_ControlE), .opE(opE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .Imm_Ext_E(Imm_Ext_E),
        .RDE(RDE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .Mem_to_RegM(Mem_to_RegM), .funct3M(funct3M), .RDM(RDM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        RegWriteE = 0; Mem_to_RegE = 0; MemReadE = 0; MemWriteE = 0;
        BranchE = 0; JumpE = 0; ALUSrcE = 0; funct3E = 0; ALU_ControlE = 0;
        opE = 7'b0110011; RD1E = 0; RD2E = 0; PCE = 0; PCPlus4E = 0;
        Imm_Ext_E = 0; RDE = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        RegWriteE = 1; Mem_to_RegE = 2'b01; MemReadE = 1; MemWriteE = 1;
        BranchE = 1; JumpE = 1; ALUSrcE = $urandom_range(1); funct3E = 3'($urandom);
        ALU_ControlE = 4'($urandom); opE = 7'($urandom); RD1E = $urandom; RD2E = $urandom;
        PCE = $urandom; PCPlus4E = $urandom | 32'h1; Imm_Ext_E = $urandom; RDE = 5'h1F;
        ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); ResultW = $urandom;
        #2;
        checks++;
        if ({RegWriteM, MemReadM, MemWriteM, Mem_to_RegM, funct3M, RDM} !== 13'd0) begin
            errors++;
            $display("FAIL reset_ctrl_async: got %h expected 0",
                     {RegWriteM, MemReadM, MemWriteM, Mem_to_RegM, funct3M, RDM});
        end
        checks++;
        if ({ALUResultM, WriteDataM, PCPlus4M} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data_async: got %h expected 0", {ALUResultM, WriteDataM, PCPlus4M});
        end
        tick();
        checks++;
        if ({RegWriteM, PCPlus4M, RDM} !== 38'd0) begin
            errors++;
            $display("FAIL reset_held_over_edge: got %h expected 0", {RegWriteM, PCPlus4M, RDM});
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_add_fwd();
        RD1E = 5; ResultW = 7; ForwardAE = FWD_WB; RD2E = 3; ALUSrcE = 0;
        ALU_ControlE = ALU_ADD; RDE = 4; RegWriteE = 1;
        tick();
        checks++;
        if (ALUResultM !== 32'd10) begin
            errors++;
            $display("FAIL add_fwd_result: got %h expected %h", ALUResultM, 32'd10);
        end
        checks++;
        if (RDM !== 5'd4 || RegWriteM !== 1'b1) begin
            errors++;
            $display("FAIL add_fwd_ctrl: got rd=%0d rw=%b expected rd=4 rw=1", RDM, RegWriteM);
        end
        clear_inputs();
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ctl [12];
        logic [31:0] a [12];
        logic [31:0] b [12];
        logic [31:0] exp [12];
        ctl[0]  = ALU_SUB;  a[0]  = 32'd3;         b[0]  = 32'd5;         exp[0]  = 32'hFFFF_FFFE;
        ctl[1]  = ALU_SRA;  a[1]  = 32'h8000_0000; b[1]  = 32'd4;         exp[1]  = 32'hF800_0000;
        ctl[2]  = ALU_SLT;  a[2]  = 32'hFFFF_FFFF; b[2]  = 32'd1;         exp[2]  = 32'd1;
        ctl[3]  = ALU_SLTU; a[3]  = 32'hFFFF_FFFF; b[3]  = 32'd1;         exp[3]  = 32'd0;
        ctl[4]  = ALU_AND;  a[4]  = 32'hF0F0_1234; b[4]  = 32'h0FF0_FF00; exp[4]  = 32'h00F0_1200;
        ctl[5]  = ALU_OR;   a[5]  = 32'hF0F0_1234; b[5]  = 32'h0FF0_FF00; exp[5]  = 32'hFFF0_FF34;
        ctl[6]  = ALU_XOR;  a[6]  = 32'hF0F0_1234; b[6]  = 32'h0FF0_FF00; exp[6]  = 32'hFF00_ED34;
        ctl[7]  = ALU_SLL;  a[7]  = 32'd1;         b[7]  = 32'h23;        exp[7]  = 32'd8;
        ctl[8]  = ALU_SRL;  a[8]  = 32'h8000_0000; b[8]  = 32'd4;         exp[8]  = 32'h0800_0000;
        ctl[9]  = ALU_ADD;  a[9]  = 32'hFFFF_FFFF; b[9]  = 32'd2;         exp[9]  = 32'd1;
        ctl[10] = 4'hA;     a[10] = 32'h1234_5678; b[10] = 32'h1;         exp[10] = 32'd0;
        ctl[11] = ALU_SLT;  a[11] = 32'd1;         b[11] = 32'hFFFF_FFFF; exp[11] = 32'd0;
        for (int i = 0; i < 12; i++) begin
            RD1E = a[i]; RD2E = b[i]; ALU_ControlE = ctl[i];
            tick();
            checks++;
            if (ALUResultM !== exp[i]) begin
                errors++;
                $display("FAIL alu_op_%0d ctl=%0d: got %h expected %h", i, ctl[i], ALUResultM, exp[i]);
            end
        end
        clear_inputs();
        opE = OP_LUI; ALUSrcE = 1; RD1E = 32'h5555_5555; Imm_Ext_E = 32'h1234_5000; ALU_ControlE = ALU_ADD;
        tick();
        checks++;
        if (ALUResultM !== 32'h1234_5000) begin
            errors++;
            $display("FAIL lui: got %h expected %h", ALUResultM, 32'h1234_5000);
        end
        opE = OP_AUIPC; PCE = 32'h0000_0100;
        tick();
        checks++;
        if (ALUResultM !== 32'h1234_5100) begin
            errors++;
            $display("FAIL auipc: got %h expected %h", ALUResultM, 32'h1234_5100);
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        opE = 7'b1100011; BranchE = 1; funct3E = F3_BGE; ALUSrcE = 1;
        RD1E = 32'hFFFF_FFFE; RD2E = 32'hFFFF_FFFE; PCE = 32'h100; Imm_Ext_E = 32'h20;
        #1;
        checks++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'h120) begin
            errors++;
            $display("FAIL bge_equal: got src=%b tgt=%h expected src=1 tgt=00000120", PCSrcE, PCTargetE);
        end
        RD1E = 32'hFFFF_FFFD;
        #1;
        checks++;
        if (PCSrcE !== 1'b0) begin
            errors++;
            $display("FAIL bge_less: got %b expected 0", PCSrcE);
        end
        funct3E = F3_BLTU; RD1E = 32'd1; RD2E = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (PCSrcE !== 1'b1) begin
            errors++;
            $display("FAIL bltu: got %b expected 1", PCSrcE);
        end
        funct3E = F3_BLT;
        #1;
        checks++;
        if (PCSrcE !== 1'b0) begin
            errors++;
            $display("FAIL blt_signed: got %b expected 0", PCSrcE);
        end
        funct3E = 3'b010; RD1E = 32'd7; RD2E = 32'd7;
        #1;
        checks++;
        if (PCSrcE !== 1'b0) begin
            errors++;
            $display("FAIL f3_010_never: got %b expected 0", PCSrcE);
        end
        funct3E = F3_BEQ; Imm_Ext_E = 32'd7; RD2E = 32'd8;
        #1;
        checks++;
        if (PCSrcE !== 1'b0) begin
            errors++;
            $display("FAIL beq_ignores_imm: got %b expected 0", PCSrcE);
        end
        RD2E = 32'd7; BranchE = 0;
        #1;
        checks++;
        if (PCSrcE !== 1'b0) begin
            errors++;
            $display("FAIL beq_no_branch: got %b expected 0", PCSrcE);
        end
        clear_inputs();
    endtask

    task automatic test_jalr();
        RD1E = 32'h200; RD2E = 32'd3; ALU_ControlE = ALU_ADD;
        tick();
        opE = OP_JALR; JumpE = 1; ForwardAE = FWD_MEM; Imm_Ext_E = 32'd4; ALUSrcE = 1;
        RD1E = 32'h9999; PCE = 32'h400; PCPlus4E = 32'h404; RegWriteE = 1;
        Mem_to_RegE = WB_PC4; RDE = 5'd1;
        #1;
        checks++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'h206) begin
            errors++;
            $display("FAIL jalr_target: got src=%b tgt=%h expected src=1 tgt=00000206", PCSrcE, PCTargetE);
        end
        tick();
        checks++;
        if (PCPlus4M !== 32'h404 || Mem_to_RegM !== WB_PC4) begin
            errors++;
            $display("FAIL jalr_link: got pc4=%h wb=%b expected pc4=00000404 wb=10", PCPlus4M, Mem_to_RegM);
        end
        opE = OP_JAL; ForwardAE = FWD_REG; Imm_Ext_E = 32'hFFFF_FFF0;
        #1;
        checks++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'h3F0) begin
            errors++;
            $display("FAIL jal_target: got src=%b tgt=%h expected src=1 tgt=000003f0", PCSrcE, PCTargetE);
        end
        clear_inputs();
    endtask

    task automatic test_store_bubble();
        MemWriteE = 1; ALUSrcE = 1; ForwardBE = FWD_WB; ResultW = 32'hDEAD_BEEF;
        RD2E = 32'h1111_2222; RD1E = 32'h1000; Imm_Ext_E = 32'd8; funct3E = 3'b010;
        tick();
        checks++;
        if (WriteDataM !== 32'hDEAD_BEEF || MemWriteM !== 1'b1) begin
            errors++;
            $display("FAIL store_fwd_data: got wd=%h mw=%b expected wd=deadbeef mw=1", WriteDataM, MemWriteM);
        end
        checks++;
        if (ALUResultM !== 32'h1008 || funct3M !== 3'b010) begin
            errors++;
            $display("FAIL store_addr: got %h f3=%b expected 00001008 f3=010", ALUResultM, funct3M);
        end
        ForwardBE = 2'b11;
        tick();
        checks++;
        if (WriteDataM !== 32'h1111_2222) begin
            errors++;
            $display("FAIL fwd_11_as_reg: got %h expected 11112222", WriteDataM);
        end
        clear_inputs();
        #1;
        checks++;
        if (PCSrcE !== 1'b0) begin
            errors++;
            $display("FAIL bubble_pcsrc: got %b expected 0", PCSrcE);
        end
        tick();
        checks++;
        if ({RegWriteM, MemWriteM, MemReadM} !== 3'b000) begin
            errors++;
            $display("FAIL bubble_ctrl: got %b expected 000", {RegWriteM, MemWriteM, MemReadM});
        end
    endtask

    task automatic test_reset_mid();
        MemReadE = 1; RDE = 5'd7; Mem_to_RegE = WB_MEM; ALUSrcE = 1; Imm_Ext_E = 32'h44;
        tick();
        checks++;
        if (MemReadM !== 1'b1 || RDM !== 5'd7 || ALUResultM !== 32'h44) begin
            errors++;
            $display("FAIL load_capture: got mr=%b rd=%0d alu=%h expected mr=1 rd=7 alu=00000044",
                     MemReadM, RDM, ALUResultM);
        end
        #2;
        opE = OP_JAL; JumpE = 1; PCE = 32'h40; Imm_Ext_E = 32'h10;
        rst = 1'b1;
        #1;
        checks++;
        if (MemReadM !== 1'b0 || RDM !== 5'd0 || ALUResultM !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_clear: got mr=%b rd=%0d alu=%h expected all 0", MemReadM, RDM, ALUResultM);
        end
        checks++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'h50) begin
            errors++;
            $display("FAIL reset_mid_redirect: got src=%b tgt=%h expected src=1 tgt=00000050", PCSrcE, PCTargetE);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_add_fwd();
        test_alu_ops();
        test_branch();
        test_jalr();
        test_store_bubble();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
